// File: rtl/mux_scan_sequencer.sv
// Scans the enabled channels of a 4:1 mux, dwelling DWELL cycles on each select,
// and packs the last-dwell-cycle samples into a 4-bit frame with a valid/ready output.
module mux_scan_sequencer #(
   parameter int unsigned DWELL = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_continuous,
   input  logic [3:0] i_en_mask,
   output logic [1:0] o_sel,
   input  logic       i_mux_y,
   output logic [3:0] o_frame,
   output logic       o_frame_valid,
   input  logic       i_frame_ready,
   output logic       o_busy,
   output logic       o_overrun,
   input  logic       i_clr_ovr
);

   localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

   typedef enum logic {StIdle, StScan} state_e;

   state_e          r_state, w_state_d;
   logic [3:0]      r_mask, w_mask_d;
   logic [1:0]      r_sel, w_sel_d;
   logic [CntW-1:0] r_cnt, w_cnt_d;
   logic [3:0]      r_shadow, w_shadow_d;
   logic [3:0]      r_frame, w_frame_d;
   logic            r_frame_valid, w_frame_valid_d;
   logic            r_overrun, w_overrun_d;
   logic [3:0]      w_cand;
   logic            w_load, w_drop;

   function automatic logic [1:0] f_lowest(input logic [3:0] m);
      logic [1:0] r;
      r = '0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   function automatic logic f_has_next(input logic [3:0] m, input logic [1:0] s);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (m[i] && (i > int'(s))) r = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [1:0] f_next(input logic [3:0] m, input logic [1:0] s);
      logic [1:0] r;
      r = s;
      for (int i = 3; i >= 0; i--) begin
         if (m[i] && (i > int'(s))) r = 2'(i);
      end
      return r;
   endfunction

   always_comb begin
      w_state_d       = r_state;
      w_mask_d        = r_mask;
      w_sel_d         = r_sel;
      w_cnt_d         = r_cnt;
      w_shadow_d      = r_shadow;
      w_frame_d       = r_frame;
      w_frame_valid_d = r_frame_valid;
      w_overrun_d     = r_overrun;
      w_load          = 1'b0;
      w_drop          = 1'b0;
      w_cand          = r_shadow;
      w_cand[r_sel]   = i_mux_y;

      if (i_clr_ovr) w_overrun_d = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (i_start && (i_en_mask != 4'b0000)) begin
               w_state_d  = StScan;
               w_mask_d   = i_en_mask;
               w_sel_d    = f_lowest(i_en_mask);
               w_cnt_d    = '0;
               w_shadow_d = '0;
            end
         end
         StScan: begin
            if (r_cnt != CntLast) begin
               w_cnt_d = r_cnt + CntW'(1);
            end else begin
               w_shadow_d = w_cand;
               if (f_has_next(r_mask, r_sel)) begin
                  w_sel_d = f_next(r_mask, r_sel);
                  w_cnt_d = '0;
               end else begin
                  // Frame complete: load if the output slot is free or being drained now
                  if (!r_frame_valid || i_frame_ready) w_load = 1'b1;
                  else                                  w_drop = 1'b1;
                  if (i_continuous && (i_en_mask != 4'b0000)) begin
                     w_mask_d   = i_en_mask;
                     w_sel_d    = f_lowest(i_en_mask);
                     w_cnt_d    = '0;
                     w_shadow_d = '0;
                  end else begin
                     w_state_d = StIdle;
                  end
               end
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_load) begin
         w_frame_d       = w_cand;
         w_frame_valid_d = 1'b1;
      end else if (r_frame_valid && i_frame_ready) begin
         w_frame_valid_d = 1'b0;
      end
      if (w_drop) w_overrun_d = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= StIdle;
         r_mask        <= '0;
         r_sel         <= '0;
         r_cnt         <= '0;
         r_shadow      <= '0;
         r_frame       <= '0;
         r_frame_valid <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_mask        <= w_mask_d;
         r_sel         <= w_sel_d;
         r_cnt         <= w_cnt_d;
         r_shadow      <= w_shadow_d;
         r_frame       <= w_frame_d;
         r_frame_valid <= w_frame_valid_d;
         r_overrun     <= w_overrun_d;
      end
   end

   assign o_sel         = r_sel;
   assign o_frame       = r_frame;
   assign o_frame_valid = r_frame_valid;
   assign o_overrun     = r_overrun;
   assign o_busy        = (r_state == StScan);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed and randomized scans checked against a model that derives select order,
// frame timing and frame contents directly from the enable mask and mux inputs.
module tb_mux_scan_sequencer;

   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst_n, start, continuous, mux_y, frame_ready, clr_ovr;
   logic [3:0] en_mask, frame, mux_i;
   logic [1:0] sel;
   logic       frame_valid, busy, overrun;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // 4:1 mux model: Y follows the selected data input combinationally
   assign mux_y = mux_i[sel];

   mux_scan_sequencer #(.DWELL(DW)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_continuous  (continuous),
      .i_en_mask     (en_mask),
      .o_sel         (sel),
      .i_mux_y       (mux_y),
      .o_frame       (frame),
      .o_frame_valid (frame_valid),
      .i_frame_ready (frame_ready),
      .o_busy        (busy),
      .o_overrun     (overrun),
      .i_clr_ovr     (clr_ovr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One non-continuous scan with frame_ready=1; optionally pulses start mid-scan.
   task automatic do_scan(input logic [3:0] m, input logic [3:0] iv, input bit poke);
      int ch[$];
      int n;
      for (int i = 0; i < 4; i++) if (m[i]) ch.push_back(i);
      n       = ch.size();
      en_mask = m;
      mux_i   = iv;
      start   = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < n * DW; t++) begin
         chk("scan_sel", 32'(sel), 32'(ch[t / DW]));
         chk("scan_busy", 32'(busy), 32'd1);
         chk("scan_valid", 32'(frame_valid), 32'd0);
         start = (poke && (t == DW + 1)) ? 1'b1 : 1'b0;
         tick();
      end
      start = 1'b0;
      chk("done_valid", 32'(frame_valid), 32'd1);
      chk("done_frame", 32'(frame), 32'(iv & m));
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_sel", 32'(sel), 32'(ch[n - 1]));
      chk("done_ovr", 32'(overrun), 32'd0);
      tick();
      chk("drain_valid", 32'(frame_valid), 32'd0);
   endtask

   initial begin
      logic [3:0] iv1, iv2, m;
      rst_n = 1'b0; start = 1'b0; continuous = 1'b0; frame_ready = 1'b1;
      clr_ovr = 1'b0; en_mask = 4'b0000; mux_i = 4'b0000;
      tick(2);
      rst_n = 1'b1;
      tick();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_frame", 32'(frame), 32'd0);
      chk("rst_valid", 32'(frame_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);

      do_scan(4'b1111, 4'b1010, 1'b0);
      do_scan(4'b0101, 4'b1111, 1'b0);

      en_mask = 4'b0000;
      start   = 1'b1;
      tick();
      start = 1'b0;
      chk("zmask_busy", 32'(busy), 32'd0);
      tick();
      chk("zmask_busy2", 32'(busy), 32'd0);
      chk("zmask_valid", 32'(frame_valid), 32'd0);

      do_scan(4'b1111, 4'($urandom), 1'b1);
      for (int k = 0; k < 12; k++) begin
         m = 4'($urandom_range(1, 15));
         do_scan(m, 4'($urandom), 1'($urandom_range(0, 1)));
      end

      // Backpressure, overrun, clear, then accept-and-load on one edge
      iv1 = 4'($urandom);
      iv2 = ~iv1;
      continuous = 1'b1; frame_ready = 1'b0; en_mask = 4'b1111; mux_i = iv1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(16);
      chk("bp_valid16", 32'(frame_valid), 32'd1);
      chk("bp_frame16", 32'(frame), 32'(iv1));
      chk("bp_ovr16", 32'(overrun), 32'd0);
      mux_i = iv2;
      for (int t = 17; t < 32; t++) begin
         tick();
         chk("bp_hold_frame", 32'(frame), 32'(iv1));
         chk("bp_hold_valid", 32'(frame_valid), 32'd1);
      end
      tick();
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_frame", 32'(frame), 32'(iv1));
      chk("ovr_valid", 32'(frame_valid), 32'd1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);
      tick(14);
      frame_ready = 1'b1;
      tick();
      chk("ld_frame", 32'(frame), 32'(iv2));
      chk("ld_valid", 32'(frame_valid), 32'd1);
      chk("ld_ovr", 32'(overrun), 32'd0);
      continuous = 1'b0;
      tick();
      chk("stop_drain", 32'(frame_valid), 32'd0);
      chk("stop_busy_mid", 32'(busy), 32'd1);
      tick(15);
      chk("stop_valid", 32'(frame_valid), 32'd1);
      chk("stop_frame", 32'(frame), 32'(iv2));
      chk("stop_busy", 32'(busy), 32'd0);
      tick();

      // Reset at dwell count 2 of channel 1 while a frame is pending
      continuous = 1'b1; frame_ready = 1'b0; en_mask = 4'b1111; mux_i = 4'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(22);
      chk("pre_rst_sel", 32'(sel), 32'd1);
      chk("pre_rst_valid", 32'(frame_valid), 32'd1);
      rst_n = 1'b0;
      tick(2);
      chk("mrst_sel", 32'(sel), 32'd0);
      chk("mrst_frame", 32'(frame), 32'd0);
      chk("mrst_valid", 32'(frame_valid), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_ovr", 32'(overrun), 32'd0);
      rst_n = 1'b1; continuous = 1'b0; frame_ready = 1'b1;
      tick();
      do_scan(4'b1111, 4'($urandom), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
